// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default operand width.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SA_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sum1bcc.sv
// One-bit full-adder cell: out is the sum bit, z is the carry out.
module sum1bcc (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic out,
  output logic z
);

  assign out = x ^ y ^ c;
  assign z   = (x & y) | (c & (x ^ y));

endmodule

// File: rtl/serial_adder_nb.sv
// Bit-serial WIDTH-bit adder: one sum1bcc cell, LSB first, start/busy/done handshake.
// Defining SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder_nb
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_out;
  logic             w_z;

  sum1bcc u_cell (
    .x   (r_a_sr[0]),
    .y   (r_b_sr[0]),
    .c   (r_carry),
    .out (w_out),
    .z   (w_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The result registers are refreshed as DONE is left, so sum/cout stay
  // frozen through the next RUN; in DONE itself they come straight from the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum_sr <= {w_out, r_sum_sr[WIDTH-1:1]};
          r_carry  <= w_z;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_sum  <= r_sum_sr;
          r_cout <= r_carry;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    sum  = r_sum;
    cout = r_cout;
    case (r_state)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        sum  = r_sum_sr;
        cout = r_carry;
      end
      default: ;
    endcase
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_c_msb;

  // Carry into the top bit is the carry consumed on the last RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_msb <= 1'b0;
    end else if (r_state == S_RUN && r_cnt == LAST_CNT) begin
      r_c_msb <= r_carry;
    end
  end

  assign ovf = r_c_msb ^ cout;
`endif

endmodule

// File: tb/tb_serial_adder_nb.sv
// Directed, table-driven bench for serial_adder_nb at WIDTH=4 (ovf checked when SERIAL_ADDER_OVF_EN is set).
module tb_serial_adder_nb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_nb #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one addition from IDLE and check latency, result and hold behaviour.
  task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    a = ia; b = ib; cin = icin; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_first", busy, 1);
    a = ~ia; b = ~ib; cin = ~icin;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 4);
    check("busy_in_done", busy, 0);
    check("sum", sum, es);
    check("cout", cout, eco);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, eov);
`endif
    tick();
    check("done_single", done, 0);
    check("sum_hold", sum, es);
    check("cout_hold", cout, eco);
    $display("add a=%b b=%b cin=%b -> sum=%b cout=%b (exp %b %b ovf %b) lat=%0d",
             ia, ib, icin, sum, cout, es, eco, eov, lat);
  endtask

  initial begin
    int pulses;
    int lat;
    int cyc;
    int last;
    int p;
    int bad_hold;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[2] = '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
    vecs[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[6] = '{4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1};
    vecs[7] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++)
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov);

    // Exhaustive sweep against an arithmetic model.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int tot;
          int sr;
          logic [4:0] t5;
          tot = ai + bi + ci;
          t5  = tot[4:0];
          sr  = ((ai >= 8) ? ai - 16 : ai) + ((bi >= 8) ? bi - 16 : bi) + ci;
          run_add(ai[3:0], bi[3:0], ci[0], t5[3:0], t5[4], (sr > 7 || sr < -8));
        end
      end
    end

    // start held through RUN with operands changing: one pulse, captured operands used.
    a = 4'b0101; b = 4'b0011; cin = 1'b0; start = 1'b1;
    tick();
    a = 4'b1111; b = 4'b1111;
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (done) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_sum", sum, 4'b1000);
    check("held_cout", cout, 0);
    tick();
    check("held_idle_done", done, 0);
    check("held_idle_busy", busy, 0);
    tick();
    check("held_reaccept", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("held2_latency", lat, 4);
    check("held2_sum", sum, 4'b1110);
    check("held2_cout", cout, 1);
    $display("held-start second add -> sum=%b cout=%b", sum, cout);
    tick();

    // Reset in the second RUN cycle.
    a = 4'b0101; b = 4'b0011; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    $display("reset mid-run -> busy=%b done=%b sum=%b cout=%b", busy, done, sum, cout);
    run_add(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);

    // Back-to-back with start tied high.
    a = vecs[0].a; b = vecs[0].b; cin = vecs[0].cin; start = 1'b1;
    p = 0; cyc = 0; last = 0; bad_hold = 0;
    while (p < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        check("b2b_sum", sum, vecs[p].s);
        check("b2b_cout", cout, vecs[p].co);
        if (p > 0) check("b2b_period", cyc - last, 6);
        $display("b2b pulse %0d at cycle %0d sum=%b cout=%b", p, cyc, sum, cout);
        last = cyc;
        p++;
        if (p < 4) begin
          a = vecs[p].a; b = vecs[p].b; cin = vecs[p].cin;
        end
      end else if (p > 0 && sum !== vecs[p-1].s) begin
        bad_hold++;
      end
    end
    start = 1'b0;
    check("b2b_count", p, 4);
    check("b2b_hold", bad_hold, 0);
    tick();
    tick();
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_nb.md
# serial_adder_nb

Bit-serial WIDTH-bit adder built around the team's 1-bit full-adder cell `sum1bcc`. It is the stage directly upstream of that cell: it latches two parallel operands and presents one bit pair plus the stored carry to the cell each clock, LSB first. It shifts the cell's sum bit into a result register and feeds the cell's carry back through a flip-flop. It produces a WIDTH-bit sum and carry-out after WIDTH cycles, using a start/busy/done handshake.

## Interface
- WIDTH, 4, operand and result width in bits; legal range is 2 to 32
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin an addition; sampled only in IDLE
- a  in  WIDTH  operand A; captured when start is accepted
- b  in  WIDTH  operand B; captured when start is accepted
- cin  in  1  carry-in; captured when start is accepted
- busy  out  1  high while in RUN
- done  out  1  single-cycle pulse; high while in DONE
- sum  out  WIDTH  result; held stable from DONE until the next accepted start
- cout  out  1  final carry-out; held with sum
- ovf  out  1  signed overflow; present only when SERIAL_ADDER_OVF_EN is defined

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0
  - go to RUN
- IDLE, start=0: stay in IDLE; sum and cout hold their values.
- RUN, each cycle:
  - cell inputs: x=a_sr[0], y=b_sr[0], c=carry
  - sum_sr <= {out, sum_sr[WIDTH-1:1]}
  - carry <= z
  - a_sr and b_sr shift right by one bit
  - cnt <= cnt+1
- RUN exit: when cnt==WIDTH-1, that cycle's edge moves the FSM to DONE.
- DONE:
  - sum=sum_sr, cout=carry, done=1
  - unconditionally return to IDLE on the next edge
- start is ignored in RUN and in DONE; it is never queued.
- Operand inputs a, b and cin may change freely after the start cycle.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, WIDTH+1 bits; no truncation beyond that.
- Counter width: $clog2(WIDTH).
- Reset, including mid-RUN or in DONE: state=IDLE, and busy, done, sum, cout, ovf, carry, cnt and all shift registers clear to 0.
- Reset dominates start in the same cycle.

## Timing
- Accepted start at edge k: busy=1 from edge k through edge k+WIDTH.
- done=1 for exactly one cycle, after edge k+WIDTH; busy=0 in that cycle.
- Earliest next start: sampled at edge k+WIDTH+2 (IDLE reached at edge k+WIDTH+1).
- Throughput: one addition per WIDTH+2 cycles.
- done and busy are never high in the same cycle.
- Outputs are registered; there is no combinational path from the inputs to any output.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - extra register c_msb captures the carry into bit WIDTH-1, i.e. the carry value used on the last RUN cycle
  - ovf = c_msb XOR cout, valid with done and held with sum
  - ovf resets to 0
- SERIAL_ADDER_OVF_EN undefined: ovf port and c_msb are absent; all other behaviour is identical.

## Structure
- Shared package serial_adder_pkg contains:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - a default-WIDTH constant
- Sub-module: exactly one instance of sum1bcc (port order x, y, c, out, z; out=sum bit, z=carry). No other adder logic.
- Unused state encoding 2'd3 returns to IDLE.

## Test plan
All scenarios use WIDTH=4.
- a=0101, b=0011, cin=0 -> after 4 busy cycles, done pulse with sum=1000, cout=0, ovf=1.
- a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0; a=0111, b=0000, cin=1 -> sum=1000, cout=0, ovf=1.
- Exhaustive sweep: all 512 combinations of a, b, cin -> {cout,sum} equals a+b+cin, and done occurs exactly 4 cycles after each accepted start.
- start held high through RUN, with a and b changed mid-run -> only one done pulse, result uses the originally captured operands; the next start is accepted in IDLE.
- rst asserted in the second RUN cycle -> next cycle: IDLE, busy=0, done=0, sum=0, cout=0; a fresh start then completes correctly.
- Back-to-back: start tied high -> done pulses every 6 cycles, each with the correct result and sum stable between pulses.
